// File: rtl/maxpool_ctrl.sv
// 2x2 stride-2 max-pooling controller for a row-major conv sample stream.
// The first row of each row pair is reduced into a line buffer; the second emits pooled results.
module maxpool_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MAX_DIM = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pooling_ctrl,
    input  logic [5:0]        map_dim,
    input  logic [5:0]        num_maps,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              pooling_finish
);

    localparam int unsigned DIM_W    = 6;
    localparam int unsigned LB_DEPTH = MAX_DIM / 2;
    localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DIM_W-1:0]    dim_q, dim_d;
    logic [DIM_W-1:0]    nmaps_q, nmaps_d;
    logic [DIM_W-1:0]    col_q, col_d;
    logic [DIM_W-1:0]    row_q, row_d;
    logic [DIM_W-1:0]    map_q, map_d;
    logic [DATA_W-1:0]   pair_q, pair_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                finish_q, finish_d;

    logic [DATA_W-1:0]   line_buf [LB_DEPTH];
    logic [LB_AW-1:0]    lb_idx_c;
    logic [DATA_W-1:0]   lb_rd_c;
    logic                lb_we_c;
    logic [DATA_W-1:0]   hmax_c;
    logic [DATA_W-1:0]   vmax_c;
    logic                accept_c;
    logic                last_col_c;
    logic                last_row_c;
    logic                last_map_c;

    // Signed horizontal and vertical reductions of the 2x2 window
    always_comb begin
        lb_idx_c   = LB_AW'(col_q >> 1);
        lb_rd_c    = line_buf[lb_idx_c];
        hmax_c     = ($signed(in_data) > $signed(pair_q)) ? in_data : pair_q;
        vmax_c     = ($signed(hmax_c) > $signed(lb_rd_c)) ? hmax_c : lb_rd_c;
        accept_c   = in_valid && in_ready_q;
        last_col_c = (col_q == dim_q - DIM_W'(1));
        last_row_c = (row_q == dim_q - DIM_W'(1));
        last_map_c = (map_q == nmaps_q - DIM_W'(1));
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        dim_d       = dim_q;
        nmaps_d     = nmaps_q;
        col_d       = col_q;
        row_d       = row_q;
        map_d       = map_q;
        pair_d      = pair_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        lb_we_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pooling_ctrl) begin
                    dim_d   = map_dim;
                    nmaps_d = num_maps;
                    col_d   = '0;
                    row_d   = '0;
                    map_d   = '0;
                    if ((map_dim < DIM_W'(2)) || (num_maps == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = EVEN_ROW;
                    end
                end
            end

            EVEN_ROW, ODD_ROW: begin
                if (!pooling_ctrl) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                    map_d   = '0;
                end else if (accept_c) begin
                    if (!col_q[0]) begin
                        pair_d = in_data;
                    end else if (state_q == EVEN_ROW) begin
                        lb_we_c = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = vmax_c;
                    end

                    // Trailing odd column/row fall out naturally: never an odd col, always an even row
                    if (last_col_c) begin
                        col_d = '0;
                        if (last_row_c) begin
                            row_d = '0;
                            if (last_map_c) begin
                                map_d   = '0;
                                state_d = DONE;
                            end else begin
                                map_d   = map_q + DIM_W'(1);
                                state_d = EVEN_ROW;
                            end
                        end else begin
                            row_d   = row_q + DIM_W'(1);
                            state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end

            DONE: begin
                if (!pooling_ctrl) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == EVEN_ROW) || (state_d == ODD_ROW);
        finish_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dim_q       <= '0;
            nmaps_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            map_q       <= '0;
            pair_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dim_q       <= dim_d;
            nmaps_q     <= nmaps_d;
            col_q       <= col_d;
            row_q       <= row_d;
            map_q       <= map_d;
            pair_q      <= pair_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            finish_q    <= finish_d;
        end
    end

    // Line buffer holds only horizontal maxima; every read follows a write in the same job
    always_ff @(posedge clk) begin
        if (lb_we_c) begin
            line_buf[lb_idx_c] <= hmax_c;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign pooling_finish = finish_q;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Randomized self-checking bench for maxpool_ctrl against a window-level pooling model.
module tb_maxpool_ctrl;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          pooling_ctrl;
    logic [5:0]    map_dim;
    logic [5:0]    num_maps;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          pooling_finish;

    int n_cmp = 0;
    int n_bad = 0;

    logic signed [DW-1:0] stim [$];

    maxpool_ctrl #(.DATA_W(DW), .MAX_DIM(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .pooling_ctrl   (pooling_ctrl),
        .map_dim        (map_dim),
        .num_maps       (num_maps),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .pooling_finish (pooling_finish)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample k closes a pooling window when it sits on an odd row and odd column of its map
    function automatic bit closes_window(input int dim, input int k);
        int area = dim * dim;
        int r = (k % area) / dim;
        int c = k % dim;
        return (r % 2 == 1) && (c % 2 == 1);
    endfunction

    function automatic logic [DW-1:0] window_max(input int dim, input int k);
        int area = dim * dim;
        int base = (k / area) * area;
        int r = (k % area) / dim;
        int c = k % dim;
        logic signed [DW-1:0] m = stim[base + (r - 1) * dim + (c - 1)];
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (stim[base + (r - 1 + i) * dim + (c - 1 + j)] > m)
                    m = stim[base + (r - 1 + i) * dim + (c - 1 + j)];
            end
        end
        return m;
    endfunction

    task automatic fill_ramp(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(DW'(i));
    endtask

    task automatic fill_rand(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(DW'($urandom));
    endtask

    task automatic start_job(input int dim, input int nmaps);
        @(negedge clk);
        pooling_ctrl = 1'b1;
        map_dim      = 6'(dim);
        num_maps     = 6'(nmaps);
        @(posedge clk);
        @(negedge clk);
    endtask

    // mode 0: full job; 1: abort by dropping pooling_ctrl; 2: reset after stop_after samples
    task automatic run_job(input string tag, input int dim, input int nmaps,
                           input int gap_min, input int gap_max,
                           input int mode, input int stop_after);
        int n = dim * dim * nmaps;
        int lim = (mode == 0) ? n : stop_after;
        int seen = 0;
        start_job(dim, nmaps);
        check_eq({tag, "_ready_at_start"}, 32'(in_ready), 32'd1);
        for (int k = 0; k < lim; k++) begin
            bit exp_v;
            int gaps;
            in_valid = 1'b1;
            in_data  = stim[k];
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            exp_v = closes_window(dim, k);
            if (out_valid) seen++;
            check_eq({tag, "_out_valid"}, 32'(out_valid), 32'(exp_v));
            if (exp_v) check_eq({tag, "_out_data"}, 32'(out_data), 32'(window_max(dim, k)));
            gaps = (k == lim - 1) ? 0 : int'($urandom_range(gap_min, gap_max));
            for (int g = 0; g < gaps; g++) begin
                @(posedge clk);
                @(negedge clk);
                check_eq({tag, "_gap_quiet"}, 32'(out_valid), 32'd0);
            end
        end
        if (mode == 0) begin
            check_eq({tag, "_finish"}, 32'(pooling_finish), 32'd1);
            check_eq({tag, "_ready_in_done"}, 32'(in_ready), 32'd0);
            check_eq({tag, "_out_count"}, 32'(seen), 32'(nmaps * (dim / 2) * (dim / 2)));
            pooling_ctrl = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_finish_drop"}, 32'(pooling_finish), 32'd0);
        end else if (mode == 1) begin
            pooling_ctrl = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                @(negedge clk);
                check_eq({tag, "_abort_valid"}, 32'(out_valid), 32'd0);
                check_eq({tag, "_abort_finish"}, 32'(pooling_finish), 32'd0);
                check_eq({tag, "_abort_ready"}, 32'(in_ready), 32'd0);
            end
        end else begin
            rst = 1'b1;
            pooling_ctrl = 1'b0;
            #1;
            check_eq({tag, "_rst_ready"}, 32'(in_ready), 32'd0);
            check_eq({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
            check_eq({tag, "_rst_data"}, 32'(out_data), 32'd0);
            check_eq({tag, "_rst_finish"}, 32'(pooling_finish), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_post_rst_idle"}, 32'(in_ready), 32'd0);
        end
    endtask

    task automatic degenerate(input string tag, input int dim, input int nmaps);
        start_job(dim, nmaps);
        check_eq({tag, "_finish"}, 32'(pooling_finish), 32'd1);
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        pooling_ctrl = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_finish_drop"}, 32'(pooling_finish), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        pooling_ctrl = 1'b0;
        map_dim      = '0;
        num_maps     = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_ready", 32'(in_ready), 32'd0);
        check_eq("reset_valid", 32'(out_valid), 32'd0);
        check_eq("reset_data", 32'(out_data), 32'd0);
        check_eq("reset_finish", 32'(pooling_finish), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        fill_ramp(16);
        run_job("basic4x4", 4, 1, 0, 0, 0, 0);

        stim.delete();
        stim.push_back(-16'sd3);
        stim.push_back(-16'sd8);
        stim.push_back(-16'sd1);
        stim.push_back(-16'sd7);
        run_job("signed2x2", 2, 1, 0, 0, 0, 0);

        fill_rand(50);
        run_job("odd5x5x2", 5, 2, 0, 0, 0, 0);

        fill_ramp(16);
        run_job("stall", 4, 1, 1, 1, 0, 0);

        fill_rand(16);
        run_job("abort", 4, 1, 0, 0, 1, 6);
        fill_rand(32);
        run_job("after_abort", 4, 2, 0, 1, 0, 0);

        fill_rand(16);
        run_job("reset_mid", 4, 1, 0, 0, 2, 6);
        fill_ramp(16);
        run_job("after_reset", 4, 1, 0, 0, 0, 0);

        degenerate("dim1", 1, 1);
        degenerate("maps0", 4, 0);

        for (int j = 0; j < 8; j++) begin
            int d = int'($urandom_range(2, 9));
            int m = int'($urandom_range(1, 3));
            fill_rand(d * d * m);
            run_job("random", d, m, 0, 2, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
